// File: rtl/dxy_pipe.sv
// Two-stage pipeline computing a*a*(C -/+ 2*bx) mod 2^N with valid/ready handshakes
// on both sides, a square-overflow flag and a delivered-results counter.
module dxy_pipe #(
    parameter int          N = 16,
    parameter int unsigned C = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] bx,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic         ovf,
    output logic [15:0]  count
);

    localparam logic [N-1:0] C_N = N'(C);

    logic           r_s1_valid;
    logic [2*N-1:0] r_sq;
    logic [N-1:0]   r_t;
    logic           r_s2_valid;
    logic [N-1:0]   r_res;
    logic           r_ovf;
    logic [15:0]    r_count;

    logic [N-1:0]   w_two_bx;
    logic [N-1:0]   w_t;
    logic [2*N-1:0] w_sq;
    logic [N-1:0]   w_prod;
    logic           w_in_hs;
    logic           w_out_hs;
    logic           w_s2_load;

    assign w_two_bx  = {bx[N-2:0], 1'b0};
    assign w_t       = mode ? (C_N - w_two_bx) : (C_N + w_two_bx);
    assign w_sq      = {{N{1'b0}}, a} * {{N{1'b0}}, a};
    assign w_prod    = r_sq[N-1:0] * r_t;

    // S2 can take a new result when empty or when its current one leaves now.
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_sq       <= '0;
            r_t        <= '0;
        end else if (w_in_hs) begin
            r_s1_valid <= 1'b1;
            r_sq       <= w_sq;
            r_t        <= w_t;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_res      <= w_prod;
            r_ovf      <= (r_sq[2*N-1:N] != '0);
        end else if (w_out_hs) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_out_hs) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_valid = r_s2_valid;
    assign res       = r_res;
    assign ovf       = r_ovf;
    assign count     = r_count;

endmodule

// File: tb/tb_dxy_pipe.sv
// Randomized and directed checks of dxy_pipe against a queue-based model of
// the arithmetic, two-deep buffering, latency and delivered-result count.
module tb_dxy_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] bx;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic        ovf;
    logic [15:0] count;

    dxy_pipe #(.N(16), .C(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .bx        (bx),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf),
        .count     (count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] q_res[$];
    logic        q_ovf[$];
    int          q_cyc[$];
    logic [15:0] m_count = 16'd0;
    int          m_hs    = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] prev_res;
    logic        prev_ovf;
    logic [15:0] d_res;
    logic        d_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference arithmetic written directly from the formula with wide integers.
    task automatic model_push(input logic [15:0] ia, input logic [15:0] ib, input logic im);
        longint unsigned sq, fac;
        sq  = longint'(ia) * longint'(ia);
        if (im) fac = (65536 + 1 - ((2 * longint'(ib)) % 65536)) % 65536;
        else    fac = (1 + 2 * longint'(ib)) % 65536;
        q_res.push_back(16'((sq * fac) % 65536));
        q_ovf.push_back(sq >= 65536);
        q_cyc.push_back(cyc);
    endtask

    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic im, input logic ordy, output logic acc);
        logic exp_ov;
        in_valid  = iv;
        a         = ia;
        bx        = ib;
        mode      = im;
        out_ready = ordy;
        #1;
        exp_ov = (q_res.size() > 0) && (cyc - q_cyc[0] >= 2);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, (q_res.size() < 2) || ordy);
        chk("count", count, m_count);
        if (hold_prev) begin
            chk("hold_res", res, prev_res);
            chk("hold_ovf", ovf, prev_ovf);
        end
        if (out_valid && ordy && q_res.size() > 0) begin
            chk("res", res, q_res[0]);
            chk("ovf", ovf, q_ovf[0]);
            d_res = res;
            d_ovf = ovf;
            void'(q_res.pop_front());
            void'(q_ovf.pop_front());
            void'(q_cyc.pop_front());
            m_count = m_count + 16'd1;
            m_hs++;
        end
        hold_prev = out_valid && !ordy;
        prev_res  = res;
        prev_ovf  = ovf;
        acc = iv && in_ready;
        if (acc) model_push(ia, ib, im);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        bx        = 16'h0042;
        mode      = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        q_res.delete();
        q_ovf.delete();
        q_cyc.delete();
        m_count   = 16'd0;
        m_hs      = 0;
        hold_prev = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_res", res, 16'h0000);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_count", count, 16'h0000);
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic drain;
        logic acc;
        int   guard;
        guard = 0;
        while (q_res.size() > 0 && guard < 20) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("drain_empty", q_res.size(), 0);
    endtask

    initial begin
        logic        acc;
        logic [15:0] pa[3];
        logic [15:0] pb[3];
        int          idx;
        int          guard;

        @(negedge clk);
        do_reset(3);

        // 9 * (1 - 8) = -63
        step(1'b1, 16'd3, 16'd4, 1'b1, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        chk("d033_res", d_res, 16'hFFC1);
        chk("d033_ovf", d_ovf, 1'b0);
        chk("d033_count", count, 16'd1);

        step(1'b1, 16'd3, 16'd4, 1'b0, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        chk("d034_res", d_res, 16'h0051);
        chk("d034_ovf", d_ovf, 1'b0);

        step(1'b1, 16'h0100, 16'd0, 1'b1, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        chk("d035_res", d_res, 16'h0000);
        chk("d035_ovf", d_ovf, 1'b1);

        // Backpressure: two fit, third waits until the consumer resumes.
        do_reset(1);
        pa = '{16'd5, 16'd7, 16'd300};
        pb = '{16'd1, 16'h8000, 16'd9};
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pa[idx], pb[idx], i[0], 1'b0, acc);
            if (acc) idx++;
        end
        chk("d036_accepted", idx, 2);
        chk("d036_in_ready", in_ready, 1'b0);
        guard = 0;
        while (idx < 3 && guard < 10) begin
            step(1'b1, pa[idx], pb[idx], 1'b0, 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        drain();
        chk("d036_count", count, 16'd3);

        // Reset with both stages full discards everything.
        step(1'b1, 16'd11, 16'd2, 1'b1, 1'b0, acc);
        step(1'b1, 16'd12, 16'd3, 1'b0, 1'b0, acc);
        step(1'b1, 16'd13, 16'd4, 1'b0, 1'b0, acc);
        do_reset(1);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            step(1'($urandom_range(0, 3) != 0), ra, 16'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Counter wrap after 65536 deliveries.
        do_reset(1);
        guard = 0;
        while (m_hs < 65536 && guard < 65600) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);
            guard++;
        end
        chk("d038_handshakes", m_hs, 65536);
        chk("d038_count_wrap", count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dxy_pipe.md
DXY_PIPE -- requirements
Module: dxy_pipe

Interface
REQ-001 Parameter N, default 16, data width of operands and result (N >= 4).
REQ-002 Parameter C, default 1, constant term of the factor (C - 2*bx) / (C + 2*bx), taken mod 2^N.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair on a/bx/mode valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  N  base operand.
REQ-008 bx  input  N  coordinate operand.
REQ-009 mode  input  1  1: res = a*a*(C - 2*bx); 0: res = a*a*(C + 2*bx).
REQ-010 out_valid  output  1  res/ovf hold a result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 res  output  N  result, mod 2^N.
REQ-013 ovf  output  1  set when a*a exceeded N bits for this result.
REQ-014 count  output  16  number of results delivered since reset.

Function
REQ-015 Input handshake: operands captured when in_valid && in_ready; output handshake: result consumed when out_valid && out_ready.
REQ-016 Two pipeline stages, S1 and S2, each with its own valid bit; no other state machine.
REQ-017 S1 captures: sq = a*a at full 2N-bit precision; t = (C - 2*bx) mod 2^N if mode=1, else (C + 2*bx) mod 2^N; 2*bx is bx shifted left by 1, MSB dropped.
REQ-018 S2 captures: res = (sq[N-1:0] * t) mod 2^N; ovf = (sq[2N-1:N] != 0).
REQ-019 S2 loads when S1 valid and (S2 empty or out_ready); S1 loads when S1 empty or S1 moving into S2 the same cycle.
REQ-020 in_ready = !S1_valid || (!S2_valid || out_ready); combinational from registered state and out_ready only, never from in_valid.
REQ-021 Latency: a pair accepted in cycle k appears with out_valid=1 in cycle k+2 when out_ready held high.
REQ-022 Throughput: one result per cycle with in_valid and out_ready held high; no bubbles.
REQ-023 Backpressure: with out_ready low, block holds at most 2 results (S1+S2); in_ready drops once both are full.
REQ-024 While out_valid=1 and out_ready=0, res and ovf hold stable.
REQ-025 Results leave in acceptance order; none dropped or duplicated.
REQ-026 Simultaneous consume at S2 and accept at S1 in one cycle both take effect.
REQ-027 count increments by 1 on each output handshake; wraps 0xFFFF -> 0x0000.
REQ-028 Arithmetic is unsigned bit-pattern mod 2^N; negative factors appear as two's complement patterns.

Reset
REQ-029 On rst=1 at a clock edge: S1_valid=0, S2_valid=0, res=0, ovf=0, count=0.
REQ-030 Reset mid-operation discards all in-flight operands; out_valid=0 the cycle after reset.
REQ-031 in_ready=1 in the first cycle after reset is released.
REQ-032 Inputs sampled while rst=1 are ignored.

Verification
REQ-033 N=16, C=1, mode=1, a=3, bx=4, out_ready=1 -> two cycles later res=0xFFC1 (9*-7), ovf=0, count=1.
REQ-034 Same operands, mode=0 -> res=0x0051 (9*9), ovf=0.
REQ-035 a=0x0100, bx=0, mode=1 -> res=0x0000, ovf=1.
REQ-036 out_ready=0, push 3 pairs back-to-back -> in_ready=0 after 2 accepts, res stable; out_ready=1 -> 3 results in order, count=3.
REQ-037 Reset asserted with S1 and S2 full -> next cycle out_valid=0, count=0, in_ready=1.
REQ-038 65536 consecutive output handshakes -> count wraps to 0x0000.
